// File: rtl/apb_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_fifo_pkg                                                       |
// | Register map, STATUS/IRQ bit positions and CTRL fields shared by   |
// | the APB FIFO bridge.                                               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package apb_fifo_pkg;

   // Register word index, i.e. byte offset from BASE_ADDR divided by 4
   typedef enum logic [2:0] {
      REG_TX_DATA   = 3'd0,   // 0x00
      REG_RX_DATA   = 3'd1,   // 0x04
      REG_STATUS    = 3'd2,   // 0x08
      REG_CTRL      = 3'd3,   // 0x0C
      REG_THRESH    = 3'd4,   // 0x10
      REG_LEVEL     = 3'd5,   // 0x14
      REG_RX_EXPECT = 3'd6,   // 0x18
      REG_IRQ_STAT  = 3'd7    // 0x1C
   } reg_idx_t;

   // Byte span of the register window
   localparam logic [31:0] REG_SPAN = 32'h20;

   // STATUS bit positions
   localparam int ST_EMPTY_TX        = 0;
   localparam int ST_ALMOST_EMPTY_TX = 1;
   localparam int ST_FULL_TX         = 2;
   localparam int ST_EMPTY_RX        = 3;
   localparam int ST_ALMOST_FULL_RX  = 4;
   localparam int ST_FULL_RX         = 5;
   localparam int ST_RX_BUSY         = 6;

   // IRQ_STAT bit positions
   localparam int IRQ_TX_LOW  = 0;
   localparam int IRQ_RX_HIGH = 1;
   localparam int IRQ_RX_DONE = 2;
   localparam int IRQ_RX_OVF  = 3;
   localparam int IRQ_BITS    = 4;

   // CTRL field positions
   localparam int CTRL_TX_FLUSH = 0;
   localparam int CTRL_RX_FLUSH = 1;
   localparam int CTRL_MASK_LSB = 8;

   // Replace the byte lanes of cur selected by strb with those of wr
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = wr[8*b +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo                                                          |
// | Single-clock first-word-fall-through FIFO with flush and count.    |
// | Head reads 0 while empty; storage itself is never reset.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage write on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy update; flush overrides any push/pop
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_fifo_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_fifo_bridge                                                    |
// | Zero-wait-state APB slave fronting a TX FIFO (APB -> stream) and   |
// | an RX FIFO (stream -> APB) with thresholds, an expected-word       |
// | counter and sticky maskable interrupts.                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module apb_fifo_bridge
   import apb_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'd8,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 16
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic [31:0]             paddr,
   input  logic [2:0]              pprot,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr,
   input  logic                    read_fifo_tx,
   output logic [DATA_WIDTH-1:0]   fifo_r_data_tx,
   output logic                    empty_tx,
   output logic                    almost_empty_tx,
   input  logic                    write_fifo_rx,
   input  logic [DATA_WIDTH-1:0]   fifo_w_data_rx,
   output logic                    full_rx,
   output logic                    almost_full_rx,
   output logic                    end_rx,
   output logic                    irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("apb_fifo_bridge: DATA_WIDTH must be 32");
      end
      if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("apb_fifo_bridge: DEPTH must be a power of 2 in 4..256");
      end
   endgenerate

   // Protection attributes carry no meaning for this slave
   logic unused_pprot;
   assign unused_pprot = ^pprot;

   logic [31:0]           offset;
   logic                  in_map;
   logic                  access;
   logic                  err;
   logic                  wr_ok;
   logic                  rd_ok;
   reg_idx_t              idx;
   logic [DATA_WIDTH-1:0] rdata;
   logic [31:0]           status_word;

   logic [DATA_WIDTH-1:0] rx_head;
   logic [CW-1:0]         tx_count, rx_count;
   logic                  tx_full, rx_empty;
   logic                  tx_push, rx_pop, tx_flush, rx_flush;

   logic [IRQ_BITS-1:0]   irq_mask;
   logic [IRQ_BITS-1:0]   irq_stat;
   logic [IRQ_BITS-1:0]   irq_set;
   logic [IRQ_BITS-1:0]   irq_clr;
   logic [CW-1:0]         tx_low, rx_high;
   logic [31:0]           rx_cnt;
   logic [31:0]           thresh_merged;
   logic                  ae_prev, af_prev;
   logic                  rx_push_ok, rx_busy, exp_wr;

   // Clamp a 16-bit threshold field to the FIFO depth
   function automatic logic [CW-1:0] sat(input logic [15:0] v);
      return (v > 16'(DEPTH)) ? CW'(DEPTH) : v[CW-1:0];
   endfunction

   assign offset = paddr - BASE_ADDR;
   assign in_map = (paddr >= BASE_ADDR) && (offset < REG_SPAN);
   assign idx    = reg_idx_t'(offset[4:2]);
   assign access = psel & penable;
   assign pready = access;

   // Classify the current address/direction as an erroring access
   always_comb begin
      err = 1'b0;
      if (!in_map || paddr[1:0] != 2'b00) begin
         err = 1'b1;
      end else if (pwrite) begin
         case (idx)
            REG_RX_DATA, REG_STATUS, REG_LEVEL: err = 1'b1;
            REG_TX_DATA:                        err = tx_full;
            default:                            err = 1'b0;
         endcase
      end else begin
         case (idx)
            REG_TX_DATA: err = 1'b1;
            REG_RX_DATA: err = rx_empty;
            default:     err = 1'b0;
         endcase
      end
   end

   assign wr_ok   = presetn & access & pwrite & ~err;
   assign rd_ok   = presetn & access & ~pwrite & ~err;
   assign pslverr = presetn & access & err;

   assign tx_push  = wr_ok && idx == REG_TX_DATA;
   assign rx_pop   = rd_ok && idx == REG_RX_DATA;
   assign tx_flush = wr_ok && idx == REG_CTRL && pstrb[0] && pwdata[CTRL_TX_FLUSH];
   assign rx_flush = wr_ok && idx == REG_CTRL && pstrb[0] && pwdata[CTRL_RX_FLUSH];
   assign exp_wr   = wr_ok && idx == REG_RX_EXPECT;

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk(pclk), .rst_n(presetn), .push(tx_push), .pop(read_fifo_tx),
      .flush(tx_flush), .wdata(pwdata), .head(fifo_r_data_tx),
      .count(tx_count), .empty(empty_tx), .full(tx_full)
   );

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk(pclk), .rst_n(presetn), .push(write_fifo_rx), .pop(rx_pop),
      .flush(rx_flush), .wdata(fifo_w_data_rx), .head(rx_head),
      .count(rx_count), .empty(rx_empty), .full(full_rx)
   );

   assign almost_empty_tx = (tx_count <= tx_low);
   assign almost_full_rx  = (rx_count >= rx_high);
   assign rx_push_ok      = write_fifo_rx & ~full_rx;
   assign rx_busy         = |rx_cnt;
   // A simultaneous RX_EXPECT rewrite restarts the count, so no completion
   assign end_rx          = presetn & ~exp_wr & rx_push_ok & (rx_cnt == 32'd1);

   // Gather STATUS flags into their bit positions
   always_comb begin
      status_word                     = '0;
      status_word[ST_EMPTY_TX]        = empty_tx;
      status_word[ST_ALMOST_EMPTY_TX] = almost_empty_tx;
      status_word[ST_FULL_TX]         = tx_full;
      status_word[ST_EMPTY_RX]        = rx_empty;
      status_word[ST_ALMOST_FULL_RX]  = almost_full_rx;
      status_word[ST_FULL_RX]         = full_rx;
      status_word[ST_RX_BUSY]         = rx_busy;
   end

   // Register read multiplexer
   always_comb begin
      rdata = '0;
      case (idx)
         REG_RX_DATA:   rdata = rx_head;
         REG_STATUS:    rdata = status_word;
         REG_CTRL:      rdata[CTRL_MASK_LSB +: IRQ_BITS] = irq_mask;
         REG_THRESH:    rdata = {16'(rx_high), 16'(tx_low)};
         REG_LEVEL:     rdata = {16'(rx_count), 16'(tx_count)};
         REG_RX_EXPECT: rdata = rx_cnt;
         REG_IRQ_STAT:  rdata[IRQ_BITS-1:0] = irq_stat;
         default:       rdata = '0;
      endcase
   end

   assign prdata = rd_ok ? rdata : '0;

   assign thresh_merged = merge_bytes({16'(rx_high), 16'(tx_low)}, pwdata, pstrb);

   // CTRL mask and THRESH registers with byte-lane writes
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         irq_mask <= '0;
         tx_low   <= CW'(1);
         rx_high  <= CW'(DEPTH - 1);
      end else if (wr_ok) begin
         if (idx == REG_CTRL && pstrb[1]) irq_mask <= pwdata[CTRL_MASK_LSB +: IRQ_BITS];
         if (idx == REG_THRESH) begin
            tx_low  <= sat(thresh_merged[15:0]);
            rx_high <= sat(thresh_merged[31:16]);
         end
      end
   end

   // Expected RX word countdown; a write reloads, accepted pushes decrement
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         rx_cnt <= '0;
      end else if (exp_wr) begin
         rx_cnt <= merge_bytes(rx_cnt, pwdata, pstrb);
      end else if (rx_push_ok && rx_busy) begin
         rx_cnt <= rx_cnt - 32'd1;
      end
   end

   always_comb begin
      irq_set              = '0;
      irq_set[IRQ_TX_LOW]  = almost_empty_tx & ~ae_prev;
      irq_set[IRQ_RX_HIGH] = almost_full_rx & ~af_prev;
      irq_set[IRQ_RX_DONE] = end_rx;
      irq_set[IRQ_RX_OVF]  = write_fifo_rx & full_rx;
   end

   assign irq_clr = (wr_ok && idx == REG_IRQ_STAT && pstrb[0]) ? pwdata[IRQ_BITS-1:0] : '0;

   // Sticky interrupt status; a new event wins over a same-cycle clear
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         irq_stat <= '0;
         ae_prev  <= 1'b1;
         af_prev  <= 1'b0;
      end else begin
         irq_stat <= (irq_stat & ~irq_clr) | irq_set;
         ae_prev  <= almost_empty_tx;
         af_prev  <= almost_full_rx;
      end
   end

   assign irq = presetn & |(irq_stat & irq_mask);

endmodule
`default_nettype wire

// File: doc/apb_fifo_bridge.md
APB_FIFO_BRIDGE -- requirements
Module: apb_fifo_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8, byte address of register 0 (word aligned).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data and FIFO word width (32 only; 8..32 reserved for next revision, non-32 is elaboration error).
REQ-003 SHALL have parameter DEPTH, default 16, entries per FIFO, power of 2, 4..256.
REQ-004 Ports:
  pclk  in  1  sole clock, all logic rising-edge.
  presetn  in  1  reset, synchronous, active-low.
  paddr  in  32; pprot  in  3 (ignored); psel  in  1; penable  in  1; pwrite  in  1; pwdata  in  DATA_WIDTH; pstrb  in  DATA_WIDTH/8.
  pready  out  1; prdata  out  DATA_WIDTH; pslverr  out  1.
  read_fifo_tx  in  1  pop TX FIFO; fifo_r_data_tx  out  DATA_WIDTH  TX head (first-word-fall-through).
  empty_tx  out  1; almost_empty_tx  out  1  TX count <= TX_LOW threshold.
  write_fifo_rx  in  1  push fifo_w_data_rx; fifo_w_data_rx  in  DATA_WIDTH.
  full_rx  out  1; almost_full_rx  out  1  RX count >= RX_HIGH threshold.
  end_rx  out  1  one-cycle pulse, expected RX word count reached.
  irq  out  1  level, OR of enabled pending interrupts.

Function
REQ-005 pready SHALL equal psel & penable (zero wait states); every access completes in its access phase.
REQ-006 Register map, offset from BASE_ADDR: 0x00 TX_DATA W; 0x04 RX_DATA R; 0x08 STATUS R; 0x0C CTRL RW; 0x10 THRESH RW; 0x14 LEVEL R; 0x18 RX_EXPECT RW; 0x1C IRQ_STAT R/W1C.
REQ-007 pslverr SHALL assert in access phase for: address outside map, unaligned paddr[1:0]!=0, write to R-only, read of TX_DATA, write to TX_DATA when TX full, read of RX_DATA when RX empty; errored accesses have no side effect and prdata=0.
REQ-008 prdata SHALL be 0 outside a valid read access phase.
REQ-009 TX_DATA write SHALL push pwdata (pstrb ignored for FIFO, honoured for CTRL/THRESH/RX_EXPECT byte lanes) in the access-phase cycle.
REQ-010 RX_DATA read SHALL return RX head combinationally and pop it at the end of the access cycle.
REQ-011 STATUS bits [0]empty_tx [1]almost_empty_tx [2]full_tx [3]empty_rx [4]almost_full_rx [5]full_rx [6]rx_busy (expect count active); others 0.
REQ-012 LEVEL: [15:0] TX count, [31:16] RX count, each 0..DEPTH.
REQ-013 CTRL: [0] tx_flush, [1] rx_flush, self-clearing, read 0; flush empties FIFO next cycle, overriding simultaneous push/pop; [11:8] irq enable mask.
REQ-014 THRESH: [15:0] TX_LOW, [31:16] RX_HIGH, reset TX_LOW=1, RX_HIGH=DEPTH-1; values above DEPTH saturate to DEPTH.
REQ-015 Simultaneous push and pop on a non-empty, non-full FIFO SHALL keep count unchanged; pop on empty and push on full SHALL be ignored (external side silently, APB side with pslverr).
REQ-016 Pointers SHALL wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
REQ-017 RX_EXPECT write N>0 SHALL load counter and set rx_busy; each accepted RX push decrements; on reaching 0 end_rx pulses one cycle, rx_busy clears; N=0 clears rx_busy without pulse; rewrite while busy restarts count.
REQ-018 IRQ_STAT bits [0]tx_low (almost_empty_tx rising), [1]rx_high (almost_full_rx rising), [2]rx_done (end_rx), [3]rx_overflow (push on full RX); sticky, write 1 clears, set wins over simultaneous clear.
REQ-019 irq SHALL equal |(IRQ_STAT & mask), registered-free.

Reset
REQ-020 On presetn=0 at pclk edge: both FIFOs empty, pointers 0, CTRL=0, THRESH defaults, RX_EXPECT counter 0, IRQ_STAT=0.
REQ-021 Outputs during/after reset: empty_tx=1, almost_empty_tx=1, full_rx=0, almost_full_rx=0, end_rx=0, irq=0, pslverr=0, fifo_r_data_tx=0; FIFO storage not reset.
REQ-022 Reset mid-transfer SHALL abort it; no partial push/pop survives.

Structure
REQ-023 Package apb_fifo_pkg SHALL hold register offsets, STATUS/IRQ bit indices, CTRL field positions.
REQ-024 Sub-module sync_fifo (parameters DATA_WIDTH, DEPTH; push, pop, flush, count, head) SHALL be instantiated twice (TX, RX).

Verification
REQ-025 Reset, write TX_DATA 0xA5A5_0001..0x10 (16 words) -> LEVEL[15:0]=16, STATUS[2]=1; 17th write -> pslverr=1, LEVEL unchanged.
REQ-026 Push 3 RX words 0x11,0x22,0x33 -> three RX_DATA reads return 0x11,0x22,0x33; 4th read pslverr=1, prdata=0.
REQ-027 RX_EXPECT=4, enable rx_done; push 4 words -> end_rx single pulse on 4th push cycle, irq=1; W1C 0x4 -> irq=0.
REQ-028 TX count 8, simultaneous APB push and read_fifo_tx -> count stays 8, order preserved; CTRL tx_flush -> empty_tx=1 next cycle.
REQ-029 Access paddr=BASE_ADDR+0x20 and BASE_ADDR+0x2 -> pslverr=1, no state change; THRESH write RX_HIGH=4 -> almost_full_rx at 4th RX word.
